// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: popcounts each IN_WIDTH-bit slice and sums
// WINDOW_BEATS slices into one binary count, held in a one-entry output buffer.
module sc_stream_decoder #(
    parameter int IN_WIDTH     = 8,
    parameter int WINDOW_BEATS = 4,
    parameter int CNT_WIDTH    = 6,
    localparam int BW          = (WINDOW_BEATS > 1) ? $clog2(WINDOW_BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_bits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_value,
    output logic [BW-1:0]        beat_idx
);

    logic [CNT_WIDTH-1:0] acc_q, acc_d;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0] out_value_q, out_value_d;

    logic [CNT_WIDTH-1:0] psum [IN_WIDTH+1];
    logic [CNT_WIDTH-1:0] pc;
    logic [CNT_WIDTH-1:0] sum;
    logic                 last_beat;
    logic                 accept;

    // Ripple prefix sum over the slice; psum[IN_WIDTH] is the popcount.
    assign psum[0] = '0;
    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_popcount
            assign psum[gi+1] = psum[gi] + CNT_WIDTH'(in_bits[gi]);
        end
    endgenerate

    assign pc        = psum[IN_WIDTH];
    assign sum       = acc_q + pc;
    assign last_beat = (beat_q == BW'(WINDOW_BEATS - 1));

    // Only the closing beat needs a free output slot; earlier beats just accumulate.
    assign in_ready  = !(last_beat && out_valid_q && !out_ready);
    assign accept    = in_valid && in_ready && !flush;

    always_comb begin
        acc_d       = acc_q;
        beat_d      = beat_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            acc_d  = '0;
            beat_d = '0;
        end else if (accept) begin
            if (last_beat) begin
                out_value_d = sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
                beat_d      = '0;
            end else begin
                acc_d  = sum;
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            beat_q      <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else begin
            acc_q       <= acc_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign beat_idx  = beat_q;

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Stochastic-to-binary converter: the inverse of the Sobol comparator bitstream generators.
- Accepts one parallel slice of IN_WIDTH stochastic bits per beat and popcounts each slice.
- Accumulates over a fixed window of WINDOW_BEATS beats and emits the total ones count as a binary value.
- Sits at the output of SC processing elements, converting SC results back to binary for the CGRA datapath; one-entry output buffer with valid/ready on both sides.

Parameters:
- IN_WIDTH, 8, stochastic bits per input beat (matches OUT_WIDTH of the generators).
- WINDOW_BEATS, 4, beats per conversion window; must be >= 1.
- CNT_WIDTH, 6, result width; must satisfy 2^CNT_WIDTH > IN_WIDTH*WINDOW_BEATS (default max 32 fits in 6 bits).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of the current partial window.
- in_valid  in  1  in_bits carries a valid slice.
- in_ready  out  1  decoder can accept a slice this cycle.
- in_bits  in  IN_WIDTH  stochastic bit slice; bit order irrelevant.
- out_valid  out  1  out_value holds a completed result.
- out_ready  in  1  downstream accepts out_value.
- out_value  out  CNT_WIDTH  ones count of the last completed window.
- beat_idx  out  clog2(WINDOW_BEATS), min 1  index of the next beat within the window (debug/observability).

Behaviour:
- Reset (asynchronous, rst_n=0):
  - acc=0, beat_idx=0, out_valid=0, out_value=0.
  - in_ready reflects reset state (1) combinationally.
- Acceptance: a beat is accepted when in_valid & in_ready & !flush.
- pc = popcount(in_bits), width CNT_WIDTH, combinational.
- Non-final beat accepted (beat_idx < WINDOW_BEATS-1): acc <= acc + pc; beat_idx increments.
- Final beat accepted (beat_idx == WINDOW_BEATS-1):
  - out_value <= acc + pc; out_valid <= 1.
  - acc <= 0; beat_idx <= 0.
  - Latency: result is visible the cycle after the final beat is accepted.
- in_ready = !(beat_idx == WINDOW_BEATS-1 && out_valid && !out_ready).
  - Only the final beat stalls, and only when the output buffer is full and not draining.
  - Non-final beats of the next window are accepted while a result waits.
  - in_ready never depends on in_valid.
- Output side:
  - out_valid & out_ready with no new result loaded: out_valid <= 0; out_value holds its last value.
  - Output accepted and final beat accepted in the same cycle: out_valid stays 1 and out_value takes the new sum (no bubble).
  - out_value is stable while out_valid=1 and out_ready=0.
- flush=1:
  - acc <= 0, beat_idx <= 0.
  - Any in_bits presented that cycle are dropped (in_ready may still read 1; the upstream must treat flush as an abort).
  - The output register and out_valid are untouched; out_valid may still clear via out_ready in the same cycle.
- WINDOW_BEATS == 1: every accepted beat is final; acc stays 0.
- Arithmetic: unsigned throughout; the CNT_WIDTH rule guarantees no overflow; no saturation logic.
- Reset mid-window or with a pending result: all state is lost immediately; no output is produced for a partial window.

Test Plan:
- Defaults, 4 beats of 0xFF back-to-back, out_ready=1 -> one cycle after the 4th beat out_valid=1, out_value=32; beat_idx back to 0.
- Beats 0x0F, 0x01, 0x00, 0xAA -> out_value=4+1+0+4=9; then a second window of 4x 0x80 streamed immediately -> out_value=4 with no idle cycle between results.
- Backpressure: result 9 pending, out_ready=0, next window's 3 beats accepted, 4th beat sees in_ready=0 -> out_value stays 9; raise out_ready -> the 4th beat is accepted in the same cycle and the next cycle shows the new result.
- Flush after 2 beats of 0xFF, then 4 beats of 0x03 -> out_value=8, not 24; a result already pending before the flush survives unchanged.
- Reset asserted asynchronously mid-window with out_valid=1 -> out_valid, out_value, beat_idx go to 0 without a clock edge; the next full window of 0x01 gives 4.
- Loop back sobol_8 (a=5'd16, b=5'd20) over 4 beats -> out_value equals the sum of the popcounts of the generated slices; check against the bench model.
